// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch stage: PC, ROM addressing, IF/ID register, stall/redirect/halt
// Owns the program counter and captures the combinational ROM word into the IF/ID register.
module inst_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_if_pc;
  logic              r_valid;
  logic [31:0]       r_count;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [INST_W-1:0] w_inst_nxt;
  logic [ADDR_W-1:0] w_if_pc_nxt;
  logic              w_valid_nxt;
  logic [31:0]       w_count_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_state_nxt;
  end

  // In RUN, redirect beats halt, halt beats stall, stall beats advance.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_if_pc_nxt = r_if_pc;
    w_valid_nxt = r_valid;
    w_count_nxt = r_count;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = halt_req ? S_HALT : S_RUN;
      end
      S_RUN: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_inst_nxt  = NOP_WORD;
          w_valid_nxt = 1'b0;
        end else if (halt_req) begin
          w_state_nxt = S_HALT;
          w_inst_nxt  = NOP_WORD;
          w_valid_nxt = 1'b0;
        end else if (!stall) begin
          w_inst_nxt  = rom_inst;
          w_if_pc_nxt = r_pc;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = r_pc + 1'b1;
          w_count_nxt = r_count + 32'd1;
        end
      end
      S_HALT: begin
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_HALT;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_inst  <= NOP_WORD;
      r_if_pc <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_if_pc <= w_if_pc_nxt;
      r_valid <= w_valid_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign inst_addr   = r_pc;
  assign if_inst     = r_inst;
  assign if_pc       = r_if_pc;
  assign if_valid    = r_valid;
  assign halted      = (r_state == S_HALT);
  assign fetch_count = r_count;

endmodule
